// File: rtl/ram_responder.sv
// Word-addressed RAM responder for the CPU-RAM port with a fixed BUSY wait latency.
// Optional range check on the word index is enabled by defining RAM_RESPONDER_ADDR_CHECK_EN.
module ram_responder #(
   parameter int unsigned LAT   = 2,
   parameter int unsigned DEPTH = 1024
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] memaddr,
   input  logic [31:0] memstore,
   input  logic        memREN,
   input  logic        memWEN,
   output logic [31:0] ramload,
   output logic [1:0]  ramstate
);

   localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  LatCnt = 4'(LAT);

   if (LAT > 15) begin : g_lat_chk
      $error("ram_responder: LAT must be in 0..15");
   end

   // Encodings double as the ramstate code, so ramstate is the state register itself.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StAcc  = 2'd2,
      StErr  = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [29:0] idx_q, idx_d;
   logic [31:0] data_q, data_d;
   logic        wr_q, wr_d;

   logic [31:0] mem [DEPTH];

   logic range_err;
   logic req_one;
   logic hold_ok;
   logic unused_addr;

   assign unused_addr = ^memaddr[1:0];

`ifdef RAM_RESPONDER_ADDR_CHECK_EN
   assign range_err = {2'b00, memaddr[31:2]} >= 32'(DEPTH);
`else
   assign range_err = 1'b0;
`endif

   assign req_one = memREN ^ memWEN;
   // The latched transaction stays valid only while the same op and word index are held.
   assign hold_ok = (wr_q ? (memWEN & ~memREN) : (memREN & ~memWEN)) &&
                    (memaddr[31:2] == idx_q);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         wr_q    <= wr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      data_d  = data_q;
      wr_d    = wr_q;
      unique case (state_q)
         StIdle: begin
            if (memREN && memWEN) begin
               state_d = StErr;
            end else if (req_one) begin
               if (range_err) begin
                  state_d = StErr;
               end else begin
                  idx_d   = memaddr[31:2];
                  data_d  = memstore;
                  wr_d    = memWEN;
                  cnt_d   = LatCnt;
                  state_d = (LatCnt == 4'd0) ? StAcc : StWait;
               end
            end
         end
         StWait: begin
            if (!hold_ok) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d = StAcc;
               end
            end
         end
         StAcc:   state_d = StIdle;
         StErr:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Storage has no reset; a reset asserted at the ACC edge blocks the commit.
   always_ff @(posedge CLK) begin
      if (!RST && (state_q == StAcc) && wr_q) begin
         mem[idx_q[AW-1:0]] <= data_q;
      end
   end

   assign ramload  = (state_q == StAcc) ? mem[idx_q[AW-1:0]] : 32'h0;
   assign ramstate = state_q;

endmodule

// File: tb/tb_ram_responder.sv
// Directed, table-driven bench for ram_responder (LAT=2 main instance, LAT=0 side instance).
module tb_ram_responder;

   localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCS = 2'd2, ERRS = 2'd3;

   logic        CLK, RST;
   logic [31:0] memaddr, memstore, ramload;
   logic        memREN, memWEN;
   logic [1:0]  ramstate;

   logic [31:0] addr0, store0, load0;
   logic        ren0, wen0;
   logic [1:0]  state0;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        ren;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] store;
      logic [1:0]  st;
      logic        chk_load;
      logic [31:0] load;
   } vec_t;

   vec_t vecs[$];

   ram_responder #(.LAT(2), .DEPTH(1024)) u_dut (
      .CLK(CLK), .RST(RST), .memaddr(memaddr), .memstore(memstore),
      .memREN(memREN), .memWEN(memWEN), .ramload(ramload), .ramstate(ramstate)
   );

   ram_responder #(.LAT(0), .DEPTH(1024)) u_lat0 (
      .CLK(CLK), .RST(RST), .memaddr(addr0), .memstore(store0),
      .memREN(ren0), .memWEN(wen0), .ramload(load0), .ramstate(state0)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach summary");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Write-side ACC rows carry a don't-care load; every other row expects a defined ramload.
   function automatic void add(input logic ren, input logic wen, input logic [31:0] addr,
                               input logic [31:0] store, input logic [1:0] st,
                               input logic [31:0] load);
      vec_t v;
      v.ren = ren; v.wen = wen; v.addr = addr; v.store = store; v.st = st;
      v.chk_load = !((st == ACCS) && wen);
      v.load = (st == ACCS) ? load : 32'h0;
      vecs.push_back(v);
   endfunction

   function automatic void add_xfer(input logic wen, input logic [31:0] addr,
                                    input logic [31:0] store, input logic [31:0] load);
      add(!wen, wen, addr, store, FREE, 0);
      add(!wen, wen, addr, store, BUSY, 0);
      add(!wen, wen, addr, store, BUSY, 0);
      add(!wen, wen, addr, store, ACCS, load);
      add(1'b0, 1'b0, 32'h0, 32'h0, FREE, 0);
   endfunction

   initial begin
      logic [1:0] seq_st [4];
      RST = 1'b1;
      memREN = 0; memWEN = 0; memaddr = 0; memstore = 0;
      ren0 = 0; wen0 = 0; addr0 = 0; store0 = 0;

      // Write 0x10 then read it back
      add_xfer(1, 32'h10, 32'hDEADBEEF, 0);
      add_xfer(0, 32'h10, 32'h0, 32'hDEADBEEF);
      // Both requests at once: one ERROR cycle, memory untouched
      add_xfer(1, 32'h0, 32'h11111111, 0);
      add(1, 1, 32'h0, 32'hFFFFFFFF, FREE, 0);
      add(0, 0, 32'h0, 32'h0, ERRS, 0);
      add(0, 0, 32'h0, 32'h0, FREE, 0);
      add_xfer(0, 32'h0, 32'h0, 32'h11111111);
      // Address change in first BUSY cycle restarts the transaction
      add_xfer(1, 32'h20, 32'hAAAA5555, 0);
      add_xfer(1, 32'h30, 32'h30303030, 0);
      add(0, 1, 32'h20, 32'h1, FREE, 0);
      add(0, 1, 32'h24, 32'h1, BUSY, 0);
      add(0, 1, 32'h24, 32'h1, FREE, 0);
      add(0, 1, 32'h24, 32'h1, BUSY, 0);
      add(0, 1, 32'h24, 32'h1, BUSY, 0);
      add(0, 1, 32'h24, 32'h1, ACCS, 0);
      add(0, 0, 32'h0, 32'h0, FREE, 0);
      add_xfer(0, 32'h20, 32'h0, 32'hAAAA5555);
      add_xfer(0, 32'h24, 32'h0, 32'h1);
      // Abort by dropping the request
      add(0, 1, 32'h28, 32'h77, FREE, 0);
      add(0, 0, 32'h28, 32'h0, BUSY, 0);
      add(0, 0, 32'h0, 32'h0, FREE, 0);
      // Abort by op change, then the read proceeds and sees the old data
      add(0, 1, 32'h20, 32'h2, FREE, 0);
      add(1, 0, 32'h20, 32'h0, BUSY, 0);
      add(1, 0, 32'h20, 32'h0, FREE, 0);
      add(1, 0, 32'h20, 32'h0, BUSY, 0);
      add(1, 0, 32'h20, 32'h0, BUSY, 0);
      add(1, 0, 32'h20, 32'h0, ACCS, 32'hAAAA5555);
      add(0, 0, 32'h0, 32'h0, FREE, 0);
`ifdef RAM_RESPONDER_ADDR_CHECK_EN
      add(1, 0, 32'h1000, 32'h0, FREE, 0);
      add(0, 0, 32'h0, 32'h0, ERRS, 0);
      add(0, 0, 32'h0, 32'h0, FREE, 0);
`else
      add_xfer(0, 32'h1000, 32'h0, 32'h11111111);
`endif

      #2;
      chk("reset ramstate", {30'h0, ramstate}, {30'h0, FREE});
      chk("reset ramload", ramload, 32'h0);
      chk("reset lat0 ramstate", {30'h0, state0}, {30'h0, FREE});
      @(negedge CLK);
      RST = 1'b0;

      foreach (vecs[i]) begin
         @(negedge CLK);
         memREN = vecs[i].ren; memWEN = vecs[i].wen;
         memaddr = vecs[i].addr; memstore = vecs[i].store;
         #1;
         chk($sformatf("vec%0d ramstate", i), {30'h0, ramstate}, {30'h0, vecs[i].st});
         if (vecs[i].chk_load) chk($sformatf("vec%0d ramload", i), ramload, vecs[i].load);
      end

      // Reset during BUSY of a write to 0x30
      @(negedge CLK);
      memWEN = 1; memREN = 0; memaddr = 32'h30; memstore = 32'h00000BAD;
      #1 chk("rst seq free", {30'h0, ramstate}, {30'h0, FREE});
      @(negedge CLK);
      #1 chk("rst seq busy", {30'h0, ramstate}, {30'h0, BUSY});
      #1 RST = 1'b1;
      #1 chk("rst async ramstate", {30'h0, ramstate}, {30'h0, FREE});
      chk("rst async ramload", ramload, 32'h0);
      @(negedge CLK);
      memWEN = 0;
      @(negedge CLK);
      RST = 1'b0;
      memREN = 1; memaddr = 32'h30;
      seq_st[0] = FREE; seq_st[1] = BUSY; seq_st[2] = BUSY; seq_st[3] = ACCS;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge CLK);
         #1 chk($sformatf("post-rst read c%0d", k), {30'h0, ramstate}, {30'h0, seq_st[k]});
      end
      chk("post-rst read data", ramload, 32'h30303030);
      @(negedge CLK);
      memREN = 0;

      // LAT=0: back-to-back ACCESS with a FREE cycle between
      @(negedge CLK);
      wen0 = 1; addr0 = 32'h10; store0 = 32'h00005A5A;
      #1 chk("lat0 wr free", {30'h0, state0}, {30'h0, FREE});
      @(negedge CLK);
      #1 chk("lat0 wr access", {30'h0, state0}, {30'h0, ACCS});
      @(negedge CLK);
      wen0 = 0;
      #1 chk("lat0 idle", {30'h0, state0}, {30'h0, FREE});
      @(negedge CLK);
      ren0 = 1;
      #1 chk("lat0 rd c0", {30'h0, state0}, {30'h0, FREE});
      @(negedge CLK);
      #1 chk("lat0 rd c1", {30'h0, state0}, {30'h0, ACCS});
      chk("lat0 rd c1 data", load0, 32'h00005A5A);
      @(negedge CLK);
      #1 chk("lat0 rd c2", {30'h0, state0}, {30'h0, FREE});
      chk("lat0 rd c2 data", load0, 32'h0);
      @(negedge CLK);
      #1 chk("lat0 rd c3", {30'h0, state0}, {30'h0, ACCS});
      chk("lat0 rd c3 data", load0, 32'h00005A5A);
      @(negedge CLK);
      ren0 = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
